// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display blocks.
// Segment bytes are active-low: bit0=a .. bit6=g, bit7=dp.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIG_W      = 4;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Active-low gfedcba glyphs, entry 0 in the low slice: 0-9, A, b, C, d, E, F.
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0][DIG_W-1:0] digits;
        logic [NUM_DIGITS-1:0]            dp;
        logic [NUM_DIGITS-1:0]            blank;
    } seg_frame_t;

    localparam seg_frame_t FRAME_DARK = '{digits: '0, dp: '0, blank: '1};

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble + decimal point to active-low segment byte.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] seg
);

    always_comb begin
        seg                = SEG_OFF;
        seg[SEG_G:SEG_A]   = GLYPH[value];
        seg[SEG_DP]        = ~dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scanner with a blanking gap per slot and a
// valid/ready frame loader that swaps frames only at the frame boundary.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  load_blank,
    output logic [3:0]  io_sel,
    output logic [7:0]  io_seg,
    output logic        frame_tick
);

    localparam int               CNT_W    = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);

    seg_frame_t                 pend, act, load_frame;
    logic                       pend_full, pend_full_nxt;
    logic [1:0]                 idx, idx_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    seg_state_t                 state, state_nxt;
    logic                       slot_end, boundary, accept;
    logic [NUM_DIGITS-1:0][7:0] dig_seg;

    assign load_frame = {load_digits, load_dp, load_blank};
    assign slot_end   = (cnt == CNT_LAST);
    assign boundary   = slot_end && (idx == 2'd3);
    assign accept     = load_valid && load_ready;

    // Every slot opens dark; the wrap edge always lands in BLANK, so the
    // active frame can be swapped there without a torn glyph.
    always_comb begin
        cnt_nxt   = cnt + CNT_W'(1);
        idx_nxt   = idx;
        state_nxt = state;
        if (slot_end) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            state_nxt = BLANK;
        end else if (state == BLANK && cnt_nxt == CNT_SHOW) begin
            state_nxt = SHOW;
        end
    end

    // Accept and transfer are exclusive: accept needs pend_full low, transfer high.
    always_comb begin
        pend_full_nxt = pend_full;
        if (accept)
            pend_full_nxt = 1'b1;
        else if (boundary && pend_full)
            pend_full_nxt = 1'b0;
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg_hex_decode u_dec (
            .value (act.digits[i]),
            .dp    (act.dp[i]),
            .seg   (dig_seg[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            state      <= BLANK;
            pend       <= FRAME_DARK;
            act        <= FRAME_DARK;
            pend_full  <= 1'b0;
            load_ready <= 1'b1;
            frame_tick <= 1'b0;
            io_sel     <= SEL_OFF;
            io_seg     <= SEG_OFF;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            state      <= state_nxt;
            pend_full  <= pend_full_nxt;
            load_ready <= ~pend_full_nxt;
            frame_tick <= boundary;
            if (accept)
                pend <= load_frame;
            else if (boundary && pend_full)
                act <= pend;
            if (state_nxt == SHOW) begin
                io_sel <= ~(4'b0001 << idx_nxt);
                io_seg <= act.blank[idx_nxt] ? SEG_OFF : dig_seg[idx_nxt];
            end else begin
                io_sel <= SEL_OFF;
                io_seg <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_seg_scan_ctrl;

    localparam int DC = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_digits = '0;
    logic [3:0]  load_dp = '0;
    logic [3:0]  load_blank = '0;
    logic        load_ready;
    logic [3:0]  io_sel;
    logic [7:0]  io_seg;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int         obs_cyc  [32];
    logic [3:0] obs_sel  [32];
    logic [7:0] obs_seg  [32];
    logic       obs_tick [32];
    logic       obs_rdy  [32];

    logic [3:0][7:0] tbl;

    seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_dp     (load_dp),
        .load_blank  (load_blank),
        .io_sel      (io_sel),
        .io_seg      (io_seg),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    // Edges since reset release; at a negedge cyc%32==0 means a boundary just passed.
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    function automatic logic [3:0] exp_sel(input int c);
        logic [3:0][3:0] sel_tbl;
        logic [1:0]      s;
        sel_tbl = {4'h7, 4'hB, 4'hD, 4'hE};
        s = 2'((c % 32) / DC);
        if ((c % 32) % DC < BC) return 4'hF;
        return sel_tbl[s];
    endfunction

    function automatic logic [7:0] exp_seg(input int c, input logic [3:0][7:0] t);
        logic [1:0] s;
        s = 2'((c % 32) / DC);
        if ((c % 32) % DC < BC) return 8'hFF;
        return t[s];
    endfunction

    task automatic scan_frame();
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            obs_cyc[n]  = cyc;
            obs_sel[n]  = io_sel;
            obs_seg[n]  = io_seg;
            obs_tick[n] = frame_tick;
            obs_rdy[n]  = load_ready;
        end
    endtask

    task automatic wait_boundary(input string name);
        bit hit = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cyc % 32 == 0) begin hit = 1; break; end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s boundary wait: cyc=%0d, required a boundary within 40 cycles", name, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic offer(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input bit hold);
        bit done = 0;
        load_digits = d;
        load_dp     = dp;
        load_blank  = bl;
        load_valid  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (load_ready === 1'b1) begin done = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL offer: load_ready=%b, required 1 within 100 cycles", load_ready);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (io_sel !== 4'hF || io_seg !== 8'hFF || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: sel=%h seg=%h rdy=%b tick=%b, required F FF 1 0", io_sel, io_seg, load_ready, frame_tick);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (io_sel !== 4'hF || io_seg !== 8'hFF || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: sel=%h seg=%h rdy=%b, required F FF 1", io_sel, io_seg, load_ready);
        end
        tbl = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        scan_frame();
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl) ||
                obs_tick[n] !== (obs_cyc[n] % 32 == 0) || obs_rdy[n] !== 1'b1) begin
                errors++;
                $display("FAIL dark_frame cyc=%0d: sel=%h seg=%h tick=%b rdy=%b, required sel=%h seg=%h tick=%b rdy=1",
                         obs_cyc[n], obs_sel[n], obs_seg[n], obs_tick[n], obs_rdy[n],
                         exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl), (obs_cyc[n] % 32 == 0));
            end
        end
    endtask

    task automatic test_basic();
        offer(16'h4321, 4'b0000, 4'b0000, 1'b0);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_fall: load_ready=%b, required 0", load_ready);
        end
        wait_boundary("basic");
        checks++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL basic_boundary: rdy=%b tick=%b, required 1 1", load_ready, frame_tick);
        end
        tbl = {8'h99, 8'hB0, 8'hA4, 8'hF9};
        scan_frame();
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl) ||
                obs_tick[n] !== (obs_cyc[n] % 32 == 0)) begin
                errors++;
                $display("FAIL basic_frame cyc=%0d: sel=%h seg=%h tick=%b, required sel=%h seg=%h tick=%b",
                         obs_cyc[n], obs_sel[n], obs_seg[n], obs_tick[n],
                         exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl), (obs_cyc[n] % 32 == 0));
            end
        end
    endtask

    task automatic test_dp_blank();
        offer(16'h00A0, 4'b0010, 4'b1000, 1'b0);
        wait_boundary("dp_blank");
        tbl = {8'hFF, 8'hC0, 8'h08, 8'hC0};
        scan_frame();
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl)) begin
                errors++;
                $display("FAIL dp_blank_frame cyc=%0d: sel=%h seg=%h, required sel=%h seg=%h",
                         obs_cyc[n], obs_sel[n], obs_seg[n], exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit hit = 0;
        offer(16'h5678, 4'b0000, 4'b0000, 1'b1);
        load_digits = 16'h9ABC;
        load_dp     = 4'b0001;
        load_blank  = 4'b0000;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cyc % 32 == 0) begin hit = 1; break; end
            checks++;
            if (load_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_low cyc=%0d: load_ready=%b, required 0", cyc, load_ready);
            end
        end
        checks++;
        if (!hit || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_boundary: hit=%0d rdy=%b, required 1 1", hit, load_ready);
        end
        tbl = {8'h92, 8'h82, 8'hF8, 8'h80};
        scan_frame();
        load_valid = 1'b0;
        checks++;
        if (obs_rdy[0] !== 1'b0 || obs_rdy[30] !== 1'b0 || obs_rdy[31] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: rdy first=%b mid=%b last=%b, required 0 0 1", obs_rdy[0], obs_rdy[30], obs_rdy[31]);
        end
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl)) begin
                errors++;
                $display("FAIL b2b_first_frame cyc=%0d: sel=%h seg=%h, required sel=%h seg=%h",
                         obs_cyc[n], obs_sel[n], obs_seg[n], exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl));
            end
        end
        tbl = {8'h90, 8'h88, 8'h83, 8'h46};
        scan_frame();
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl) || obs_rdy[n] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second_frame cyc=%0d: sel=%h seg=%h rdy=%b, required sel=%h seg=%h rdy=1",
                         obs_cyc[n], obs_sel[n], obs_seg[n], obs_rdy[n], exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl));
            end
        end
    endtask

    task automatic test_boundary_load();
        for (int k = 0; k < 40 && (cyc % 32 != 31); k++) @(negedge clk);
        offer(16'h1357, 4'b0000, 4'b0000, 1'b0);
        checks++;
        if (cyc % 32 != 0 || load_ready !== 1'b0 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL edge_accept: cyc=%0d rdy=%b tick=%b, required boundary 0 1", cyc, load_ready, frame_tick);
        end
        tbl = {8'h90, 8'h88, 8'h83, 8'h46};
        scan_frame();
        checks++;
        if (obs_rdy[30] !== 1'b0 || obs_rdy[31] !== 1'b1) begin
            errors++;
            $display("FAIL edge_ready: rdy mid=%b last=%b, required 0 1", obs_rdy[30], obs_rdy[31]);
        end
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl) ||
                obs_tick[n] !== (obs_cyc[n] % 32 == 0)) begin
                errors++;
                $display("FAIL edge_held_frame cyc=%0d: sel=%h seg=%h tick=%b, required sel=%h seg=%h tick=%b",
                         obs_cyc[n], obs_sel[n], obs_seg[n], obs_tick[n],
                         exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl), (obs_cyc[n] % 32 == 0));
            end
        end
        tbl = {8'hF9, 8'hB0, 8'h92, 8'hF8};
        scan_frame();
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl)) begin
                errors++;
                $display("FAIL edge_new_frame cyc=%0d: sel=%h seg=%h, required sel=%h seg=%h",
                         obs_cyc[n], obs_sel[n], obs_seg[n], exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl));
            end
        end
    endtask

    task automatic test_reset_midshow();
        for (int k = 0; k < 40 && (cyc % 32 != 5); k++) @(negedge clk);
        offer(16'hEEEE, 4'b1111, 4'b0000, 1'b0);
        checks++;
        if (load_ready !== 1'b0 || io_sel !== 4'hE || io_seg !== 8'hF8) begin
            errors++;
            $display("FAIL midshow_pre: rdy=%b sel=%h seg=%h, required 0 E F8", load_ready, io_sel, io_seg);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (io_sel !== 4'hF || io_seg !== 8'hFF || load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL midshow_async: sel=%h seg=%h rdy=%b tick=%b, required F FF 1 0", io_sel, io_seg, load_ready, frame_tick);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tbl = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int f = 0; f < 2; f++) begin
            scan_frame();
            for (int n = 0; n < 32; n++) begin
                checks++;
                if (obs_sel[n] !== exp_sel(obs_cyc[n]) || obs_seg[n] !== exp_seg(obs_cyc[n], tbl) || obs_rdy[n] !== 1'b1) begin
                    errors++;
                    $display("FAIL midshow_after cyc=%0d: sel=%h seg=%h rdy=%b, required sel=%h seg=%h rdy=1",
                             obs_cyc[n], obs_sel[n], obs_seg[n], obs_rdy[n], exp_sel(obs_cyc[n]), exp_seg(obs_cyc[n], tbl));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dp_blank();
        test_back_to_back();
        test_boundary_load();
        test_reset_midshow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing controller for the 4-digit seven-segment display on the Io board. It holds a frame of four hex digits, per-digit decimal points and blank flags. It scans them onto the shared `io_sel`/`io_seg` pins with a ghost-suppression blanking gap between digits. New frames arrive through a valid/ready load port and take effect atomically at a frame boundary, so the display never shows a torn mix of old and new digits. It sits between user logic (counters, DIP/button handlers) and the top-level display pins.

## Interface
- `DIGIT_CYCLES`, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all digits off; must be ≥ 1.
- `clk` in 1: 100 MHz system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `load_valid` in 1: frame offer.
- `load_ready` out 1: controller can accept a frame.
- `load_digits` in 16: nibble *i* (`[4i+3:4i]`) is the value for digit *i*, 0x0–0xF.
- `load_dp` in 4: decimal point on, per digit.
- `load_blank` in 4: digit fully dark, per digit; overrides dp.
- `io_sel` out 4: digit enables, active-low, one-hot-low when showing.
- `io_seg` out 8: segments, active-low; bit0=a … bit6=g, bit7=dp.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers: a pending frame (digits/dp/blank plus a `pend_full` flag), an active frame, digit index `idx` (0–3), slot counter `cnt`, and state ∈ {BLANK, SHOW}.
- Slot: `cnt` counts 0..`DIGIT_CYCLES`-1.
  - BLANK while `cnt` < `BLANK_CYCLES`, otherwise SHOW.
  - At `cnt`=`DIGIT_CYCLES`-1, `cnt`←0 and `idx`←`idx`+1, wrapping 3→0.
- BLANK: `io_sel`=4'hF, `io_seg`=8'hFF.
- SHOW: `io_sel` bit `idx`=0 and the others 1. `io_seg` is the hex decode of active digit `idx` with bit7=~dp.
  - If the active blank flag for `idx` is set, `io_seg`=8'hFF.
- Decode covers 0–9 and A, b, C, d, E, F in standard seven-segment glyphs.
- Load handshake:
  - A transfer occurs on an edge where `load_valid && load_ready`.
  - `load_ready` = ~`pend_full`.
  - An accept captures all three fields and sets `pend_full`.
  - `load_valid` without `load_ready` is ignored. The source must hold its data until accepted.
- Frame boundary: the edge where `idx` wraps 3→0. On that edge:
  - if `pend_full`, active←pending and `pend_full`←0;
  - `frame_tick`=1 for that one cycle.
- A frame accepted in the same cycle as a boundary (`pend_full`=0 beforehand) waits for the next boundary.
- Repeated loads overwrite nothing, because `load_ready` is low while a frame is pending.

## Timing
- All outputs are registered. `io_sel`/`io_seg` change on the same edge that state/`idx` change.
- Reset values:
  - `io_sel`=4'hF, `io_seg`=8'hFF, `frame_tick`=0, `load_ready`=1;
  - `idx`=0, `cnt`=0, state BLANK;
  - active digits 0, dp 0, blank 4'hF (display dark);
  - `pend_full`=0.
- Reset mid-frame or mid-handshake discards both pending and active frames immediately. Outputs reach their reset values asynchronously.
- Frame period = 4·`DIGIT_CYCLES`.
- Worst-case latency from accept to first lit cycle of digit 0 = 4·`DIGIT_CYCLES` + `BLANK_CYCLES`.
- `load_ready` falls the cycle after an accept and rises the cycle after a boundary transfer.
- `cnt` width = clog2(`DIGIT_CYCLES`). No arithmetic beyond the counter increment and the 2-bit wrap of `idx`.

## Structure
- Package `seg_pkg`:
  - state enum {BLANK, SHOW};
  - segment bit-position constants;
  - 16-entry glyph constants;
  - `SEG_OFF`=8'hFF and `SEL_OFF`=4'hF.
- Sub-module `seg_hex_decode`: combinational 4-bit value + dp → 8-bit active-low segment byte. It is reused by any future display block.
- Top `seg_scan_ctrl`: counter, state machine, pending/active registers, handshake, output registers.

## Test plan
All scenarios use `DIGIT_CYCLES`=8 and `BLANK_CYCLES`=2, giving a 32-cycle frame.
- Reset → `io_sel`=F and `io_seg`=FF for a full frame. `load_ready`=1. `frame_tick` pulses every 32 cycles.
- Load digits 0x4321, dp=0, blank=0 → after the next boundary, each digit slot shows 2 cycles F/FF then 6 cycles `io_sel`=E/D/B/7 with `io_seg`=F9/A4/B0/99.
- Load 0x00A0, dp=4'b0010, blank=4'b1000 → digit0 shows C0; digit1 shows 0x08 (A with dp on); digit2 shows C0; digit3 shows FF with `io_sel`=7.
- Second `load_valid` asserted right after an accept → `load_ready`=0 until the boundary. The second frame is accepted the cycle after `load_ready` returns and is shown one frame later. No torn frame is ever observed.
- Load accepted on the exact boundary cycle → not displayed until the following boundary. `frame_tick` is still a single pulse.
- Assert `rst` mid-SHOW with a frame pending → outputs F/FF immediately. `load_ready`=1 after release. The old frame is never displayed.
